// File: rtl/lfsr_stimulus_gen_pkg.sv
// Shared types and constants for the LFSR-driven operand generators.
// Holds the FSM state encoding, default 16-bit polynomial/seed and width checks.
package lfsr_stimulus_gen_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_DONE  = S_DONE
  } state_e;

  // x^16 + x^5 + x^3 + x^2 + 1, maximal length
  localparam logic [15:0] LFSR16_POLY = 16'h002D;
  localparam logic [15:0] LFSR16_SEED = 16'h8000;

  function automatic bit lfsr_width_ok(input int unsigned w);
    return (w >= 32'd4) && ((w % 32'd2) == 32'd0);
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR register with seed load and all-zero lock-up recovery.
// Steps only when asked; a zero state is replaced by DEFAULT_SEED on the next edge.
module lfsr_galois import lfsr_stimulus_gen_pkg::*; #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] POLY         = LFSR16_POLY,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR16_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  if (!lfsr_width_ok(WIDTH)) begin : g_width_chk
    $error("lfsr_galois: WIDTH must be even and >= 4");
  end
  if (POLY[0] != 1'b1) begin : g_poly_chk
    $error("lfsr_galois: POLY bit 0 must be set");
  end

  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;

  // Next-state selection: load beats zero recovery, which beats stepping
  always_comb begin
    // POLY[0] is set, so the XOR term also supplies next[0] = msb
    w_shift = {r_lfsr[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{r_lfsr[WIDTH-1]}});
    if (load_val == {WIDTH{1'b0}}) begin
      w_load_val = DEFAULT_SEED;
    end else begin
      w_load_val = load_val;
    end
    if (load) begin
      w_next = w_load_val;
    end else if (r_lfsr == {WIDTH{1'b0}}) begin
      w_next = DEFAULT_SEED;
    end else if (step) begin
      w_next = w_shift;
    end else begin
      w_next = r_lfsr;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= DEFAULT_SEED;
    end else begin
      r_lfsr <= w_next;
    end
  end

  assign state = r_lfsr;

endmodule

// File: rtl/lfsr_stimulus_gen.sv
// Operand source for the radix-4 multiplier: issues one start per LFSR vector,
// waits for completion (bounded by TIMEOUT) and stops after num_vectors.
module lfsr_stimulus_gen import lfsr_stimulus_gen_pkg::*; #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] POLY         = LFSR16_POLY,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR16_SEED,
  parameter int unsigned      CNT_W        = 16,
  parameter int unsigned      TIMEOUT      = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               abort,
  input  logic [CNT_W-1:0]   num_vectors,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
  input  logic               radix_done,
  output logic [WIDTH/2-1:0] x,
  output logic [WIDTH/2-1:0] y,
  output logic               start_radix,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   vec_count
);

  localparam int unsigned       TCNT_W    = $clog2(TIMEOUT + 32'd1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 32'd1);

  if (!lfsr_width_ok(WIDTH)) begin : g_width_chk
    $error("lfsr_stimulus_gen: WIDTH must be even and >= 4");
  end
  if (TIMEOUT < 32'd2) begin : g_timeout_chk
    $error("lfsr_stimulus_gen: TIMEOUT must be >= 2");
  end

  state_e            r_state;
  state_e            w_state_next;
  logic [CNT_W-1:0]  r_target;
  logic [CNT_W-1:0]  r_vec_count;
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_start;
  logic              r_done;
  logic              r_busy;
  logic              r_timeout_err;

  logic              w_in_idle;
  logic              w_in_wait;
  logic              w_accept;
  logic              w_load;
  logic              w_step;
  logic              w_tout_hit;
  logic              w_tout_set;
  logic [TCNT_W-1:0] w_tcnt_inc;
  logic [CNT_W-1:0]  w_vec_inc;
  logic [WIDTH-1:0]  w_lfsr;

  // Qualified control strobes; abort masks everything
  always_comb begin
    w_in_idle  = (r_state == ST_IDLE);
    w_in_wait  = (r_state == ST_WAIT);
    w_accept   = run & w_in_idle & ~abort;
    w_load     = seed_load & w_in_idle & ~abort;
    w_step     = radix_done & w_in_wait & ~abort;
    w_tcnt_inc = r_tcnt + TCNT_W'(1);
    // The done pulse then lands TIMEOUT cycles after the start pulse
    w_tout_hit = (w_tcnt_inc == TCNT_LAST);
    w_tout_set = w_in_wait & ~radix_done & w_tout_hit & ~abort;
    w_vec_inc  = r_vec_count + CNT_W'(1);
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (run) begin
          if (num_vectors != {CNT_W{1'b0}}) begin
            w_state_next = ST_ISSUE;
          end else begin
            w_state_next = ST_DONE;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (radix_done) begin
          if (w_vec_inc == r_target) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_ISSUE;
          end
        end else if (w_tout_hit) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (abort) begin
      w_state_next = ST_IDLE;
    end else begin
      w_state_next = w_state_next;
    end
  end

  // FSM state and registered strobes, aligned with the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_start <= (w_state_next == ST_ISSUE);
      r_done  <= (w_state_next == ST_DONE);
      r_busy  <= (w_state_next != ST_IDLE);
    end
  end

  // Batch target, vector counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target      <= {CNT_W{1'b0}};
      r_vec_count   <= {CNT_W{1'b0}};
      r_timeout_err <= 1'b0;
    end else if (w_accept) begin
      r_target      <= num_vectors;
      r_vec_count   <= {CNT_W{1'b0}};
      r_timeout_err <= 1'b0;
    end else begin
      if (w_step) begin
        r_vec_count <= w_vec_inc;
      end
      if (w_tout_set) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Completion timeout counter, restarted by every start pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt <= {TCNT_W{1'b0}};
    end else if (r_state == ST_ISSUE) begin
      r_tcnt <= {TCNT_W{1'b0}};
    end else if (w_in_wait) begin
      r_tcnt <= w_tcnt_inc;
    end
  end

  lfsr_galois #(
    .WIDTH        (WIDTH),
    .POLY         (POLY),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .step     (w_step),
    .load     (w_load),
    .load_val (seed),
    .state    (w_lfsr)
  );

  assign x           = w_lfsr[WIDTH-1:WIDTH/2];
  assign y           = w_lfsr[WIDTH/2-1:0];
  assign start_radix = r_start;
  assign done        = r_done;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign vec_count   = r_vec_count;

endmodule

// File: tb/tb_lfsr_stimulus_gen.sv
// Directed bench for lfsr_stimulus_gen at default parameters.
module tb_lfsr_stimulus_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_vectors = 16'd0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'd0;
  logic        radix_done = 1'b0;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        start_radix;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [15:0] vec_count;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_done = 0;
  bit zero_seen = 1'b0;

  lfsr_stimulus_gen dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .abort       (abort),
    .num_vectors (num_vectors),
    .seed_load   (seed_load),
    .seed        (seed),
    .radix_done  (radix_done),
    .x           (x),
    .y           (y),
    .start_radix (start_radix),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .vec_count   (vec_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_radix === 1'b1) n_start <= n_start + 1;
    if (done === 1'b1) n_done <= n_done + 1;
    if (!reset && ({x, y} === 16'h0000)) zero_seen <= 1'b1;
  end

  function automatic logic [15:0] model_step(input logic [15:0] r);
    logic [15:0] n;
    n[0] = r[15];
    for (int i = 1; i < 16; i++) n[i] = r[i-1] ^ (((16'h002D >> i) & 16'h0001) != 16'h0000 ? r[15] : 1'b0);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      if (start_radix === 1'b1) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic wait_done(input int max, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      if (done === 1'b1) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({x, y} !== 16'h8000) begin
      errors++; $display("FAIL reset_xy: got %h expected 8000", {x, y});
    end
    checks++;
    if ({busy, start_radix, done, timeout_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, start_radix, done, timeout_err});
    end
    checks++;
    if (vec_count !== 16'd0) begin
      errors++; $display("FAIL reset_vec_count: got %0d expected 0", vec_count);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_v [2];
    int n;
    bit ok;
    int d0;
    exp_v[0] = 16'h8000;
    exp_v[1] = 16'h002D;
    d0 = n_done;
    num_vectors = 16'd2; run = 1'b1; tick(); run = 1'b0;
    for (int v = 0; v < 2; v++) begin
      wait_start(20, n, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_start%0d: got no start expected start", v); end
      checks++;
      if ({x, y} !== exp_v[v]) begin
        errors++; $display("FAIL basic_vec%0d: got %h expected %h", v, {x, y}, exp_v[v]);
      end
      repeat (3) tick();
      radix_done = 1'b1; tick(); radix_done = 1'b0;
    end
    wait_done(10, n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got no done expected done"); end
    checks++;
    if (vec_count !== 16'd2) begin errors++; $display("FAIL basic_vec_count: got %0d expected 2", vec_count); end
    checks++;
    if ({x, y} !== 16'h005A) begin errors++; $display("FAIL basic_final: got %h expected 005a", {x, y}); end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic_idle: got %b expected 00", {busy, done}); end
    tick();
    checks++;
    if (n_done - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", n_done - d0); end
  endtask

  task automatic test_seed();
    seed_load = 1'b1; seed = 16'h1234; tick(); seed_load = 1'b0;
    checks++;
    if ({x, y} !== 16'h1234) begin errors++; $display("FAIL seed_load: got %h expected 1234", {x, y}); end
    seed_load = 1'b1; seed = 16'h0000; tick(); seed_load = 1'b0;
    checks++;
    if ({x, y} !== 16'h8000) begin errors++; $display("FAIL seed_zero: got %h expected 8000", {x, y}); end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    int s0;
    int d0;
    num_vectors = 16'd1; run = 1'b1; tick(); run = 1'b0;
    wait_start(10, n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tout_start: got no start expected start"); end
    seed_load = 1'b1; seed = 16'h1234; tick(); seed_load = 1'b0;
    checks++;
    if ({x, y} !== 16'h8000) begin errors++; $display("FAIL seed_busy: got %h expected 8000", {x, y}); end
    wait_done(100, n, ok);
    checks++;
    if (!ok || (n + 1) !== 64) begin
      errors++; $display("FAIL tout_latency: got %0d (seen %0d) expected 64", n + 1, ok);
    end
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tout_flag: got %b expected 1", timeout_err); end
    checks++;
    if ({x, y} !== 16'h8000 || vec_count !== 16'd0) begin
      errors++; $display("FAIL tout_state: got %h/%0d expected 8000/0", {x, y}, vec_count);
    end
    tick(); tick();
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tout_sticky: got %b expected 1", timeout_err); end
    s0 = n_start;
    d0 = n_done;
    num_vectors = 16'd0; run = 1'b1; tick(); run = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tout_clear: got %b expected 0", timeout_err); end
    tick(); tick();
    checks++;
    if (n_start !== s0 || n_done !== d0 + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_pulses: got start+%0d done+%0d busy %b expected 0 1 0", n_start - s0, n_done - d0, busy);
    end
  endtask

  task automatic test_abort();
    int n;
    bit ok;
    int s0;
    int d0;
    d0 = n_done;
    num_vectors = 16'd5; run = 1'b1; tick(); run = 1'b0;
    for (int v = 0; v < 2; v++) begin
      wait_start(10, n, ok);
      tick();
      radix_done = 1'b1; tick(); radix_done = 1'b0;
    end
    wait_start(10, n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_third_start: got no start expected start"); end
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    s0 = n_start;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++;
    if (vec_count !== 16'd2 || {x, y} !== 16'h005A) begin
      errors++; $display("FAIL abort_kept: got %0d/%h expected 2/005a", vec_count, {x, y});
    end
    repeat (3) tick();
    checks++;
    if (n_done !== d0 || n_start !== s0) begin
      errors++; $display("FAIL abort_pulses: got done+%0d start+%0d expected 0 0", n_done - d0, n_start - s0);
    end
    radix_done = 1'b1; tick(); radix_done = 1'b0; tick();
    checks++;
    if ({x, y} !== 16'h005A) begin errors++; $display("FAIL stray_done: got %h expected 005a", {x, y}); end
  endtask

  task automatic test_coincide();
    int n;
    bit ok;
    num_vectors = 16'd1; run = 1'b1; tick(); run = 1'b0;
    wait_start(10, n, ok);
    repeat (63) tick();
    radix_done = 1'b1; tick(); radix_done = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL coin_done: got %b expected 1", done); end
    checks++;
    if (vec_count !== 16'd1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL coin_count: got %0d/%b expected 1/0", vec_count, timeout_err);
    end
    checks++;
    if ({x, y} !== 16'h00B4) begin errors++; $display("FAIL coin_step: got %h expected 00b4", {x, y}); end
    tick();
  endtask

  task automatic test_seed_run();
    int n;
    bit ok;
    seed_load = 1'b1; seed = 16'h1234; run = 1'b1; num_vectors = 16'd1;
    tick();
    seed_load = 1'b0; run = 1'b0;
    wait_start(10, n, ok);
    checks++;
    if (!ok || {x, y} !== 16'h1234) begin
      errors++; $display("FAIL seed_run_vec: got %h (seen %0d) expected 1234", {x, y}, ok);
    end
    tick();
    radix_done = 1'b1; tick(); radix_done = 1'b0;
    wait_done(10, n, ok);
    checks++;
    if (!ok || {x, y} !== 16'h2468) begin
      errors++; $display("FAIL seed_run_next: got %h (seen %0d) expected 2468", {x, y}, ok);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    logic [15:0] m;
    seed_load = 1'b1; seed = 16'h0000; tick(); seed_load = 1'b0;
    m = 16'h8000;
    num_vectors = 16'd300; run = 1'b1; tick(); run = 1'b0;
    for (int v = 0; v < 300; v++) begin
      wait_start(10, n, ok);
      checks++;
      if (!ok || {x, y} !== m) begin
        errors++; $display("FAIL b2b_vec%0d: got %h (seen %0d) expected %h", v, {x, y}, ok, m);
      end
      tick();
      radix_done = 1'b1; tick(); radix_done = 1'b0;
      m = model_step(m);
    end
    wait_done(10, n, ok);
    checks++;
    if (!ok || vec_count !== 16'd300) begin
      errors++; $display("FAIL b2b_count: got %0d (seen %0d) expected 300", vec_count, ok);
    end
    checks++;
    if ({x, y} !== m) begin errors++; $display("FAIL b2b_final: got %h expected %h", {x, y}, m); end
    tick();
    checks++;
    if (zero_seen !== 1'b0) begin errors++; $display("FAIL no_zero_state: got %b expected 0", zero_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seed();
    test_timeout();
    test_abort();
    test_coincide();
    test_seed_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
